// File: rtl/id_stage_pipe.sv
// Decode stage: register file, operand forwarding, load-use detection
// and the ID/EX pipeline register for the 5-stage core.
module id_stage_pipe #(
    parameter int DATA_W = 64,
    parameter int NREGS  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic              Reg2Loc,
    input  logic              ALUSrc,
    input  logic              MemtoReg,
    input  logic              RegWrite,
    input  logic              MemWrite,
    input  logic [2:0]        ALUop,
    input  logic [ADDR_W-1:0] Rn,
    input  logic [ADDR_W-1:0] Rm,
    input  logic [ADDR_W-1:0] Rd,
    input  logic [DATA_W-1:0] imm,
    input  logic              flush,
    input  logic              mem_RegWrite,
    input  logic [ADDR_W-1:0] mem_rd,
    input  logic [DATA_W-1:0] mem_result,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              stall,
    output logic              ex_valid,
    output logic              ex_RegWrite,
    output logic              ex_MemtoReg,
    output logic              ex_MemWrite,
    output logic [2:0]        ex_ALUop,
    output logic [ADDR_W-1:0] ex_rd,
    output logic [DATA_W-1:0] ex_a,
    output logic [DATA_W-1:0] ex_b,
    output logic [DATA_W-1:0] ex_sd
);

    localparam logic [ADDR_W-1:0] XZR = ADDR_W'(NREGS - 1);

    logic [DATA_W-1:0] rf [NREGS];
    logic [ADDR_W-1:0] src_b;
    logic              b_used;
    logic              hazard;
    logic [DATA_W-1:0] opa;
    logic [DATA_W-1:0] opb;

    // A load in ID/EX has no value yet, so it is never an ALU forward source
    function automatic logic [DATA_W-1:0] resolve(
        input logic [ADDR_W-1:0] s
    );
        logic [DATA_W-1:0] v;
        priority case (1'b1)
            (s == XZR): v = '0;
            (ex_valid && ex_RegWrite && !ex_MemtoReg && ex_rd == s):
                v = alu_result;
            (mem_RegWrite && mem_rd == s): v = mem_result;
            (wb_en && wb_addr == s): v = wb_data;
            default: v = rf[s];
        endcase
        return v;
    endfunction

    always_comb begin
        src_b  = Reg2Loc ? Rd : Rm;
        b_used = !(ALUSrc && !MemWrite);
        opa    = resolve(Rn);
        opb    = resolve(src_b);
        hazard = id_valid && ex_valid && ex_MemtoReg && (ex_rd != XZR)
                 && ((ex_rd == Rn) || (b_used && ex_rd == src_b));
        stall  = hazard && !flush;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                rf[i] <= '0;
            end
        end else if (wb_en && wb_addr != XZR) begin
            rf[wb_addr] <= wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid    <= 1'b0;
            ex_RegWrite <= 1'b0;
            ex_MemtoReg <= 1'b0;
            ex_MemWrite <= 1'b0;
            ex_ALUop    <= '0;
            ex_rd       <= '0;
            ex_a        <= '0;
            ex_b        <= '0;
            ex_sd       <= '0;
        end else if (flush || stall) begin
            ex_valid    <= 1'b0;
            ex_RegWrite <= 1'b0;
            ex_MemtoReg <= 1'b0;
            ex_MemWrite <= 1'b0;
        end else begin
            ex_valid    <= id_valid;
            ex_RegWrite <= id_valid && RegWrite;
            ex_MemtoReg <= id_valid && MemtoReg;
            ex_MemWrite <= id_valid && MemWrite;
            ex_ALUop    <= id_valid ? ALUop : 3'd0;
            ex_rd       <= Rd;
            ex_a        <= opa;
            ex_b        <= ALUSrc ? imm : opb;
            ex_sd       <= opb;
        end
    end

endmodule

// File: tb/tb_id_stage_pipe.sv
// Scoreboard bench for id_stage_pipe: directed decode vectors,
// expected ID/EX contents queued per cycle and checked by a monitor.
module tb_id_stage_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid, Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemWrite;
    logic [2:0]  ALUop;
    logic [4:0]  Rn, Rm, Rd;
    logic [63:0] imm;
    logic        flush, mem_RegWrite;
    logic [4:0]  mem_rd;
    logic [63:0] mem_result, alu_result;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [63:0] wb_data;
    logic        stall, ex_valid, ex_RegWrite, ex_MemtoReg, ex_MemWrite;
    logic [2:0]  ex_ALUop;
    logic [4:0]  ex_rd;
    logic [63:0] ex_a, ex_b, ex_sd;

    int compared = 0;
    int mismatched = 0;

    typedef struct {
        logic        chk, full, valid, rw, mtr, mw;
        logic [2:0]  op;
        logic [4:0]  rd;
        logic [63:0] a, b, sd;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;

    id_stage_pipe dut (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .Reg2Loc(Reg2Loc), .ALUSrc(ALUSrc), .MemtoReg(MemtoReg),
        .RegWrite(RegWrite), .MemWrite(MemWrite), .ALUop(ALUop),
        .Rn(Rn), .Rm(Rm), .Rd(Rd), .imm(imm), .flush(flush),
        .mem_RegWrite(mem_RegWrite), .mem_rd(mem_rd),
        .mem_result(mem_result), .alu_result(alu_result),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .stall(stall), .ex_valid(ex_valid), .ex_RegWrite(ex_RegWrite),
        .ex_MemtoReg(ex_MemtoReg), .ex_MemWrite(ex_MemWrite),
        .ex_ALUop(ex_ALUop), .ex_rd(ex_rd), .ex_a(ex_a), .ex_b(ex_b),
        .ex_sd(ex_sd)
    );

    function automatic exp_t ev(input logic rw, mtr, mw,
                                input logic [2:0] op, input logic [4:0] rd,
                                input logic [63:0] a, b, sd);
        exp_t e;
        e.chk = 1; e.full = 1; e.valid = 1;
        e.rw = rw; e.mtr = mtr; e.mw = mw; e.op = op; e.rd = rd;
        e.a = a; e.b = b; e.sd = sd;
        return e;
    endfunction

    function automatic exp_t zero();
        exp_t e = ev(0, 0, 0, 3'd0, 5'd0, 64'd0, 64'd0, 64'd0);
        e.valid = 0;
        return e;
    endfunction

    function automatic exp_t bub();
        exp_t e = zero();
        e.full = 0;
        return e;
    endfunction

    function automatic exp_t nc();
        exp_t e = zero();
        e.chk = 0;
        return e;
    endfunction

    task automatic idle();
        id_valid = 0; Reg2Loc = 0; ALUSrc = 0; MemtoReg = 0;
        RegWrite = 0; MemWrite = 0; ALUop = 0;
        Rn = 31; Rm = 31; Rd = 31; imm = 0; flush = 0;
        mem_RegWrite = 0; mem_rd = 0; mem_result = 0; alu_result = 0;
        wb_en = 0; wb_addr = 0; wb_data = 0;
    endtask

    task automatic ins(input logic r2l, asrc, mtr, rw, mw,
                       input logic [2:0] op, input logic [4:0] rn, rm, rd,
                       input logic [63:0] im);
        id_valid = 1; Reg2Loc = r2l; ALUSrc = asrc; MemtoReg = mtr;
        RegWrite = rw; MemWrite = mw; ALUop = op;
        Rn = rn; Rm = rm; Rd = rd; imm = im;
    endtask

    task automatic wb(input logic en, input logic [4:0] ad,
                      input logic [63:0] d);
        wb_en = en; wb_addr = ad; wb_data = d;
    endtask

    task automatic mem(input logic en, input logic [4:0] rd,
                       input logic [63:0] d);
        mem_RegWrite = en; mem_rd = rd; mem_result = d;
    endtask

    // st < 0 skips the stall check for this cycle
    task automatic step(input string nm, input exp_t e, input int st);
        #1;
        if (st >= 0) begin
            compared++;
            if (stall !== st[0]) begin
                mismatched++;
                $display("FAIL %s stall: got %0b want %0b", nm, stall, st[0]);
            end
        end
        q.push_back(e);
        @(negedge clk);
    endtask

    initial begin : monitor
        exp_t e;
        logic ok;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                if (e.chk) begin
                    compared++;
                    ok = (ex_valid === e.valid) && (ex_RegWrite === e.rw)
                         && (ex_MemtoReg === e.mtr) && (ex_MemWrite === e.mw);
                    if (e.full)
                        ok = ok && (ex_ALUop === e.op) && (ex_rd === e.rd)
                             && (ex_a === e.a) && (ex_b === e.b)
                             && (ex_sd === e.sd);
                    if (!ok) begin
                        mismatched++;
                        $display("FAIL idex@%0t: got v%0b rw%0b m2r%0b mw%0b op%0d rd%0d a=%h b=%h sd=%h want v%0b rw%0b m2r%0b mw%0b op%0d rd%0d a=%h b=%h sd=%h%s",
                                 $time, ex_valid, ex_RegWrite, ex_MemtoReg,
                                 ex_MemWrite, ex_ALUop, ex_rd, ex_a, ex_b,
                                 ex_sd, e.valid, e.rw, e.mtr, e.mw, e.op,
                                 e.rd, e.a, e.b, e.sd,
                                 e.full ? "" : " (ctrl only)");
                    end
                end
            end
        end
    end

    initial begin
        idle();
        reset = 1;
        step("rst0", zero(), -1);
        step("rst1", zero(), 0);
        // write X5 then reset clears it
        reset = 0; wb(1, 5, 64'h1234);
        step("wrx5", bub(), 0);
        wb(0, 0, 0); reset = 1;
        ins(0, 0, 0, 1, 0, 3'd2, 5, 31, 1, 0);
        step("rst_mid", zero(), 0);
        reset = 0;
        step("rdx5", ev(1, 0, 0, 3'd2, 1, 0, 0, 0), 0);
        // writeback bypass then regfile read
        wb(1, 3, 64'hAA);
        ins(0, 0, 0, 1, 0, 3'd2, 3, 31, 1, 0);
        step("wbbyp", ev(1, 0, 0, 3'd2, 1, 64'hAA, 0, 0), 0);
        wb(0, 0, 0);
        step("rfx3", ev(1, 0, 0, 3'd2, 1, 64'hAA, 0, 0), 0);
        // forwarding priority on X2
        ins(0, 0, 0, 1, 0, 3'd1, 31, 31, 2, 0);
        step("addx2", ev(1, 0, 0, 3'd1, 2, 0, 0, 0), 0);
        alu_result = 7; mem(1, 2, 9); wb(1, 2, 11);
        ins(0, 0, 0, 1, 0, 3'd1, 2, 31, 6, 0);
        step("fwd_ex", ev(1, 0, 0, 3'd1, 6, 7, 0, 0), 0);
        step("fwd_mem", ev(1, 0, 0, 3'd1, 6, 9, 0, 0), 0);
        mem(0, 0, 0);
        step("fwd_wb", ev(1, 0, 0, 3'd1, 6, 11, 0, 0), 0);
        // load-use stall then mem forward
        wb(0, 0, 0); alu_result = 0;
        ins(0, 1, 1, 1, 0, 3'd2, 31, 31, 4, 64'h10);
        step("ldx4", ev(1, 1, 0, 3'd2, 4, 0, 64'h10, 0), 0);
        ins(0, 0, 0, 1, 0, 3'd1, 31, 4, 7, 0);
        step("lu_stall", bub(), 1);
        mem(1, 4, 64'h55);
        step("lu_fwd", ev(1, 0, 0, 3'd1, 7, 0, 64'h55, 64'h55), 0);
        // XZR: dropped write, load to X31 never stalls
        mem(0, 0, 0); wb(1, 31, 64'hFF);
        ins(0, 1, 1, 1, 0, 3'd2, 31, 31, 31, 64'h20);
        step("ldx31", ev(1, 1, 0, 3'd2, 31, 0, 64'h20, 0), 0);
        ins(0, 0, 0, 1, 0, 3'd1, 31, 31, 5, 0);
        step("xzr", ev(1, 0, 0, 3'd1, 5, 0, 0, 0), 0);
        // flush beats hazard
        wb(0, 0, 0);
        ins(0, 1, 1, 1, 0, 3'd2, 31, 31, 8, 64'h10);
        step("ldx8", ev(1, 1, 0, 3'd2, 8, 0, 64'h10, 0), 0);
        ins(0, 0, 0, 1, 0, 3'd1, 8, 31, 9, 0);
        flush = 1;
        step("flush", bub(), 0);
        flush = 0;
        ins(0, 1, 1, 1, 0, 3'd2, 31, 31, 8, 64'h10);
        step("ldx8b", ev(1, 1, 0, 3'd2, 8, 0, 64'h10, 0), 0);
        // immediate form: Rm unused, no stall
        ins(0, 1, 0, 1, 0, 3'd2, 31, 8, 9, 64'h33);
        step("addi", ev(1, 0, 0, 3'd2, 9, 0, 64'h33, 0), 0);
        // store data via Reg2Loc=1 is a used source
        ins(0, 1, 1, 1, 0, 3'd2, 31, 31, 10, 64'h8);
        step("ldx10", ev(1, 1, 0, 3'd2, 10, 0, 64'h8, 0), 0);
        ins(1, 1, 0, 0, 1, 3'd2, 31, 31, 10, 64'h18);
        step("st_stall", bub(), 1);
        mem(1, 10, 64'h77);
        step("st_fwd", ev(0, 0, 1, 3'd2, 10, 0, 64'h18, 64'h77), 0);
        // invalid instruction captures zero controls
        idle(); RegWrite = 1; MemWrite = 1; MemtoReg = 1;
        step("inval", bub(), 0);
        idle();
        step("tail", nc(), -1);
        repeat (3) @(negedge clk);
        compared++;
        if (q.size() != 0) begin
            mismatched++;
            $display("FAIL drain: got %0d left want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule

// File: doc/id_stage_pipe.md
# id_stage_pipe

Parametrised, pipelined successor to the single-cycle decode datapath: owns the register file, reads and forwards operands, detects load-use hazards, and drives the ID/EX pipeline register of the 5-stage CPU. It sits between the IF/ID register and the execute stage. Writeback returns to it from the WB stage.

## Interface
Parameters:
- DATA_W, 64, register and operand width
- NREGS, 32, architectural register count; register NREGS-1 is XZR and always reads 0
- ADDR_W, 5, register address width; must satisfy 2^ADDR_W >= NREGS

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high
- id_valid  in  1  IF/ID holds a real instruction
- Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemWrite  in  1 each  decoded controls
- ALUop  in  3  ALU operation
- Rn, Rm, Rd  in  ADDR_W  source and destination fields
- imm  in  DATA_W  sign-extended immediate (ALU_imm or DT_addr, extended upstream)
- flush  in  1  branch resolved taken; kill the instruction in ID
- mem_RegWrite  in  1  EX/MEM instruction writes a register
- mem_rd  in  ADDR_W  EX/MEM destination
- mem_result  in  DATA_W  EX/MEM value
- alu_result  in  DATA_W  current ALU output for the instruction held in ID/EX
- wb_en  in  1  regfile write enable
- wb_addr  in  ADDR_W  write address
- wb_data  in  DATA_W  write data
- stall  out  1  hold PC and IF/ID this cycle (combinational)
- ex_valid  out  1  ID/EX holds a real instruction
- ex_RegWrite, ex_MemtoReg, ex_MemWrite  out  1 each  registered controls
- ex_ALUop  out  3  registered ALUop
- ex_rd  out  ADDR_W  registered Rd
- ex_a  out  DATA_W  operand A
- ex_b  out  DATA_W  operand B (imm when ALUSrc=1)
- ex_sd  out  DATA_W  store data

## Operation
- Source A = Rn. Source B = Rm when Reg2Loc=0, Rd when Reg2Loc=1.
- Source B is "used" unless ALUSrc=1 and MemWrite=0. Source A is always used.
- Operand resolution, highest priority first:
  - source == NREGS-1 -> 0
  - ex_valid & ex_RegWrite & !ex_MemtoReg & ex_rd==src -> alu_result
  - mem_RegWrite & mem_rd==src -> mem_result
  - wb_en & wb_addr==src -> wb_data
  - otherwise the regfile entry
- Regfile: NREGS x DATA_W. Written at the edge when wb_en=1 and wb_addr != NREGS-1. Writes to XZR are dropped.
- Load-use hazard: id_valid & ex_valid & ex_MemtoReg & ex_rd != NREGS-1 & ex_rd matches a used source.
- stall = hazard & !flush.
- ID/EX update each edge, in priority order:
  - reset -> all ex_* = 0
  - flush or stall -> bubble: ex_valid=0, ex_RegWrite=0, ex_MemWrite=0, ex_MemtoReg=0; data fields don't-care
  - otherwise capture: ex_valid=id_valid, controls gated by id_valid, ex_a, ex_b = ALUSrc ? imm : resolved B, ex_sd = resolved B, ex_rd = Rd
- Controls for an invalid instruction (id_valid=0) are captured as 0.

## Timing
- Latency: ID inputs to ex_* outputs is 1 cycle.
- A stall lasts exactly 1 cycle per load. The following cycle forwards the load value via mem_result.
- stall depends combinationally on the current inputs and ID/EX state only. There is no path from alu_result to stall.
- Reset mid-operation:
  - regfile cleared to 0 on the reset edge
  - ex_valid=0 and all outputs 0 the cycle after reset is sampled
  - stall=0 while ex_valid=0
- Simultaneous wb write and read of the same register returns wb_data in the same cycle.
- flush and hazard in the same cycle: stall=0, bubble inserted.

## Test plan
- Reset: write X5=0x1234, then assert reset 1 cycle. Read X5 -> 0; ex_valid=0, stall=0.
- WB bypass: wb_en=1, wb_addr=3, wb_data=0xAA, while Rn=3 in ID -> ex_a=0xAA next cycle; the regfile also holds 0xAA.
- Forward priority: ID/EX ADD to X2 with alu_result=7, mem_rd=2 with mem_result=9, wb X2=11, Rn=2 -> ex_a=7. Remove the EX match -> 9. Remove the MEM match -> 11.
- Load-use: ID/EX is an LDUR to X4 (ex_MemtoReg=1). ID holds ADD with Rm=4 -> stall=1 for 1 cycle, bubble (ex_valid=0). Next cycle, mem_result=0x55 -> ex_b=0x55.
- XZR: wb write 0xFF to reg 31; ID/EX load to X31; Rn=31 -> ex_a=0, no stall, regfile entry stays 0.
- Flush with hazard: load-use condition plus flush=1 -> stall=0, ex_valid=0 next cycle. ALUSrc=1, MemWrite=0 with Rm matching the load rd -> no stall, ex_b=imm.
